// File: rtl/pio_in_irq_multi.sv
// Avalon-MM input port: 2-flop synchroniser, per-bit edge capture (W1C) and maskable level/edge irq.
// Optional per-bit debounce filter on the synchronised inputs when PIO_IN_DEBOUNCE_EN is defined.
module pio_in_irq_multi #(
  parameter int WIDTH           = 8,
  parameter int IRQ_MODE        = 1,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

`ifdef PIO_IN_DEBOUNCE_EN
  localparam int PRIME_LOAD = (DEBOUNCE_CYCLES > 2) ? DEBOUNCE_CYCLES : 2;
`else
  localparam int PRIME_LOAD = 2;
`endif
  localparam int PW = $clog2(PRIME_LOAD + 1);

  logic [WIDTH-1:0] s1_q, s2_q, prev_q, prev_d;
  logic [WIDTH-1:0] cap_q, cap_d, mask_q, mask_d;
  logic [WIDTH-1:0] data_in, rise, fall, edge_v, clr;
  logic [PW-1:0]    prime_cnt_q, prime_cnt_d;
  logic             primed_q, primed_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;
  logic             wr_en;
  logic             unused_wd;

  assign wr_en     = chipselect & ~write_n;
  assign unused_wd = ^writedata;

`ifdef PIO_IN_DEBOUNCE_EN
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LOAD = DW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]         filt_q, filt_d;
  logic [WIDTH-1:0][DW-1:0] db_cnt_q, db_cnt_d;

  // Down-counter per bit: filtered bit flips once the raw bit has disagreed for DEBOUNCE_CYCLES cycles.
  always_comb begin
    filt_d   = filt_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      db_cnt_d[i] = DB_LOAD;
      if (!primed_q) begin
        filt_d[i] = s2_q[i];
      end else if (s2_q[i] != filt_q[i]) begin
        if (db_cnt_q[i] == '0) filt_d[i] = s2_q[i];
        else db_cnt_d[i] = db_cnt_q[i] - DW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q   <= '0;
      db_cnt_q <= '0;
    end else begin
      filt_q   <= filt_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign data_in = filt_q;
`else
  assign data_in = s2_q;
`endif

  always_comb begin
    prime_cnt_d = (prime_cnt_q != '0) ? prime_cnt_q - PW'(1) : prime_cnt_q;
    primed_d    = primed_q | (prime_cnt_q == '0);
    prev_d      = data_in;

    rise = data_in & ~prev_q;
    fall = ~data_in & prev_q;
    case (EDGE_TYPE)
      0:       edge_v = rise;
      1:       edge_v = fall;
      default: edge_v = rise | fall;
    endcase
    if (!primed_q) edge_v = '0;

    // A fresh edge in the same cycle as its clear keeps the bit set.
    clr    = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    cap_d  = (cap_q & ~clr) | edge_v;
    mask_d = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : mask_q;

    readdata_d = '0;
    case (address)
      2'd0:    readdata_d[WIDTH-1:0] = data_in;
      2'd2:    readdata_d[WIDTH-1:0] = mask_q;
      2'd3:    readdata_d[WIDTH-1:0] = cap_q;
      default: readdata_d = '0;
    endcase

    irq_d = (IRQ_MODE == 0) ? |(data_in & mask_q) : |(cap_q & mask_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q        <= '0;
      s2_q        <= '0;
      prev_q      <= '0;
      cap_q       <= '0;
      mask_q      <= '0;
      prime_cnt_q <= PW'(PRIME_LOAD);
      primed_q    <= 1'b0;
      readdata_q  <= '0;
      irq_q       <= 1'b0;
    end else begin
      s1_q        <= in_port;
      s2_q        <= s1_q;
      prev_q      <= prev_d;
      cap_q       <= cap_d;
      mask_q      <= mask_d;
      prime_cnt_q <= prime_cnt_d;
      primed_q    <= primed_d;
      readdata_q  <= readdata_d;
      irq_q       <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
